inst_axi_rd_bridge: RTL and testbench

Converts the instruction-side SRAM-like request interface driven by the fetch stage into AXI4 read transactions toward the memory system. Sits directly upstream of the fetch stage and supplies its addr_ok, data_ok and rdata. Single-beat reads only, strictly in order, with a bounded number of outstanding requests.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 10 +
 rtl/inst_axi_rd_bridge_if.sv | 39 +++
 rtl/inst_axi_rd_bridge_axi_r_resp_reg.sv | 39 +++
 rtl/inst_axi_rd_bridge.sv | 92 +++++++++
 tb/tb_inst_axi_rd_bridge.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI constants and AR channel state encoding for the instruction read bridge.
package inst_axi_rd_bridge_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'd2;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_e;
endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// Fetch-side SRAM-like bus and AXI4 read channels (AR + R) used by the bridge.
interface inst_sram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
                    input arready, rid, rdata, rresp, rlast, rvalid);
    modport slave  (input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
                    output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/inst_axi_rd_bridge_axi_r_resp_reg.sv
// One-entry R response register: captures a beat, presents it as a one-cycle data_ok.
module axi_r_resp_reg
    import inst_axi_rd_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic        rready_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
);
    logic        full_q, full_d;
    logic [31:0] data_q, data_d;
    logic        drain, capture;

    // The fetch stage never stalls data_ok, so a full entry always drains.
    assign drain    = full_q;
    assign rready_o = ~full_q | drain;
    assign capture  = rvalid_i & rready_o;

    always_comb begin
        full_d = (full_q & ~drain) | capture;
        data_d = capture ? rdata_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_ok_o = full_q;
    assign rdata_o   = data_q;
endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch SRAM-like to AXI4 single-beat read bridge, in order, bounded outstanding.
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic      clk,
    input  logic      reset,
    inst_sram_if.slave sram,
    axi_rd_if.master   axi
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    ar_state_e     state_q, state_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [2:0]    arsize_q, arsize_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          addr_ok, data_ok;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arsize_d = arsize_q;
        addr_ok  = 1'b0;
        case (state_q)
            AR_IDLE: begin
                // Slot check uses registered count: a same-cycle data_ok frees nothing yet.
                addr_ok = sram.req & (cnt_q < CW'(MAX_OUTSTANDING)) & ~reset;
                if (addr_ok) begin
                    araddr_d = sram.addr;
                    arsize_d = {1'b0, sram.size};
                    state_d  = AR_SEND;
                end
            end
            AR_SEND: if (axi.arready) state_d = AR_IDLE;
            default: state_d = AR_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (addr_ok && !data_ok)
            cnt_d = cnt_q + CW'(1);
        else if (!addr_ok && data_ok && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= AR_IDLE;
            araddr_q <= '0;
            arsize_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arsize_q <= arsize_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(data_ok && cnt_q == '0));
    end

    axi_r_resp_reg u_rresp (
        .clk       (clk),
        .reset     (reset),
        .rvalid_i  (axi.rvalid),
        .rdata_i   (axi.rdata),
        .rready_o  (axi.rready),
        .data_ok_o (data_ok),
        .rdata_o   (sram.rdata)
    );

    assign sram.addr_ok = addr_ok;
    assign sram.data_ok = data_ok;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (state_q == AR_SEND);

    logic unused_ok;
    assign unused_ok = &{1'b0, sram.wr, sram.wstrb, sram.wdata, axi.rid, axi.rresp, axi.rlast};
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench: directed scenarios plus randomized fetch/memory traffic against a queue model.
module tb_inst_axi_rd_bridge;
    import inst_axi_rd_bridge_pkg::*;

    localparam int MAX = 2;

    logic clk;
    logic reset;
    inst_sram_if sif();
    axi_rd_if    aif();

    inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .sram  (sif),
        .axi   (aif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by the fetch stage; the first word is the boot instruction.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1C00_0000) return 32'h0280_0000;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Knobs and directed commands, written only by the main process.
    logic        fetch_en, mem_en;
    int          req_pct, drop_pct, ar_pct, r_pct;
    logic        d_req, d_arready, d_rvalid;
    logic [31:0] d_addr, d_rdata;
    logic [1:0]  d_size;

    // Directed expectations: main writes entries, monitor consumes them.
    string       dq_name [256];
    int          dq_sig  [256];
    logic [31:0] dq_exp  [256];
    logic [7:0]  dwr, drd;

    // Model state, written only by the monitor.
    logic [31:0] exp_q[$];
    logic [31:0] mem_rq[$];
    logic        ar_pend, seen_aok, r_hs;
    logic [31:0] pend_addr;
    logic [1:0]  pend_size;
    int          n_acc, n_chk, n_fail;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] probe(input int sig);
        case (sig)
            0: return 32'(sif.addr_ok);
            1: return 32'(sif.data_ok);
            2: return sif.rdata;
            3: return 32'(aif.arvalid);
            4: return aif.araddr;
            5: return 32'(aif.arsize);
            default: return 32'(exp_q.size());
        endcase
    endfunction

    always @(negedge clk) begin
        while (drd != dwr) begin
            chk(dq_name[drd], probe(dq_sig[drd]), dq_exp[drd]);
            drd = drd + 8'd1;
        end
        if (reset) begin
            exp_q.delete();
            mem_rq.delete();
            ar_pend  = 1'b0;
            seen_aok = 1'b0;
            r_hs     = 1'b0;
        end else begin
            chk("addr_ok_ref", 32'(sif.addr_ok),
                32'(sif.req && !ar_pend && exp_q.size() < MAX));
            chk("arvalid_ref", 32'(aif.arvalid), 32'(ar_pend));
            chk("rready", 32'(aif.rready), 32'd1);
            if (aif.arvalid && aif.arready) begin
                chk("ar_addr", aif.araddr, pend_addr);
                chk("ar_size", 32'(aif.arsize), 32'({1'b0, pend_size}));
                chk("ar_const", {aif.arid, aif.arlen, aif.arburst, aif.arlock, aif.arcache, aif.arprot},
                    {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
                if (mem_en) mem_rq.push_back(mem_word(aif.araddr));
                ar_pend = 1'b0;
            end
            r_hs = aif.rvalid && aif.rready;
            if (r_hs && mem_rq.size() > 0) void'(mem_rq.pop_front());
            if (sif.data_ok) begin
                if (exp_q.size() == 0) chk("spurious_data_ok", 32'(sif.data_ok), 32'd0);
                else chk("rdata_order", sif.rdata, exp_q.pop_front());
            end
            if (sif.addr_ok) begin
                exp_q.push_back(mem_word(sif.addr));
                ar_pend   = 1'b1;
                pend_addr = sif.addr;
                pend_size = sif.size;
                n_acc++;
            end
            seen_aok = sif.addr_ok;
        end
    end

    // Fetch-side driver.
    initial begin
        sif.req = 1'b0; sif.wr = 1'b0; sif.size = 2'd0; sif.wstrb = 4'd0;
        sif.addr = '0; sif.wdata = '0;
        forever begin
            @(posedge clk); #2;
            if (fetch_en) begin
                if (!sif.req || seen_aok) begin
                    if ($urandom_range(99) < req_pct) begin
                        sif.req   = 1'b1;
                        sif.addr  = 32'h1C00_0000 | ($urandom & 32'h000F_FFFC);
                        sif.size  = 2'($urandom_range(2));
                        sif.wr    = 1'($urandom);
                        sif.wstrb = 4'($urandom);
                        sif.wdata = $urandom;
                    end else sif.req = 1'b0;
                end else if ($urandom_range(99) < drop_pct) sif.req = 1'b0;
            end else begin
                sif.req  = d_req;
                sif.addr = d_addr;
                sif.size = d_size;
            end
        end
    end

    // Memory-side driver.
    initial begin
        aif.arready = 1'b0; aif.rvalid = 1'b0; aif.rdata = '0;
        aif.rid = 4'd0; aif.rresp = 2'd0; aif.rlast = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (mem_en) begin
                aif.arready = ($urandom_range(99) < ar_pct);
                if (!(aif.rvalid && !r_hs)) begin
                    if (mem_rq.size() > 0 && $urandom_range(99) < r_pct) begin
                        aif.rvalid = 1'b1;
                        aif.rdata  = mem_rq[0];
                    end else begin
                        aif.rvalid = 1'b0;
                        aif.rdata  = $urandom;
                    end
                end
            end else begin
                aif.arready = d_arready;
                aif.rvalid  = d_rvalid;
                aif.rdata   = d_rdata;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic want(input string nm, input int sig, input logic [31:0] v);
        dq_name[dwr] = nm;
        dq_sig[dwr]  = sig;
        dq_exp[dwr]  = v;
        dwr = dwr + 8'd1;
    endtask

    task automatic drv(input logic rq, input logic [31:0] a, input logic ar, input logic rv, input logic [31:0] rd);
        d_req = rq; d_addr = a; d_size = 2'd2; d_arready = ar; d_rvalid = rv; d_rdata = rd;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 400 && (exp_q.size() != 0 || ar_pend); i++) cyc();
        cyc();
        want(nm, 6, 32'd0);
    endtask

    localparam logic [31:0] A0 = 32'h1C00_0000, A1 = 32'h1C00_0004, A2 = 32'h1C00_0008,
                            A3 = 32'h1C00_000C, A4 = 32'h1C00_0010;

    initial begin
        int tgt;
        dwr = '0; drd = '0; n_acc = 0; n_chk = 0; n_fail = 0;
        fetch_en = 1'b0; mem_en = 1'b0;
        req_pct = 100; drop_pct = 0; ar_pct = 100; r_pct = 100;
        drv(1'b0, '0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        want("rst_addr_ok", 0, 0); want("rst_data_ok", 1, 0); want("rst_rdata", 2, 0);
        want("rst_arvalid", 3, 0); want("rst_araddr", 4, 0); want("rst_arsize", 5, 0);

        // Single fetch latency
        cyc(); drv(1, A0, 0, 0, 0);           want("t1_addr_ok", 0, 1);
        cyc(); drv(0, 0, 1, 0, 0);            want("t1_arvalid", 3, 1); want("t1_araddr", 4, A0);
                                              want("t1_arsize", 5, 32'(SIZE_4B));
        cyc(); drv(0, 0, 0, 1, mem_word(A0)); want("t1_no_early_data", 1, 0);
        cyc(); drv(0, 0, 0, 0, 0);            want("t1_data_ok", 1, 1); want("t1_rdata", 2, 32'h0280_0000);
        cyc();                                want("t1_data_ok_pulse", 1, 0); want("t1_rdata_hold", 2, 32'h0280_0000);

        // AR backpressure
        cyc(); drv(1, A0, 0, 0, 0);           want("bp_addr_ok0", 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); drv(1, A1, 0, 0, 0);
            want("bp_arvalid", 3, 1); want("bp_araddr", 4, A0); want("bp_block", 0, 0);
        end
        cyc(); drv(1, A1, 1, 0, 0);           want("bp_hs_block", 0, 0);
        cyc(); drv(1, A1, 0, 0, 0);           want("bp_addr_ok1", 0, 1);
        cyc(); drv(0, 0, 1, 0, 0);            want("bp_araddr1", 4, A1);

        // Outstanding limit, then simultaneous inc/dec
        for (int i = 0; i < 4; i++) begin
            cyc(); drv(1, A2, 0, 0, 0);       want("lim_full", 0, 0); want("lim_arvalid", 3, 0);
        end
        cyc(); drv(1, A2, 0, 1, mem_word(A0)); want("lim_full_r", 0, 0);
        cyc(); drv(1, A2, 0, 1, mem_word(A1)); want("lim_d0", 1, 1); want("lim_no_bypass", 0, 0);
                                              want("lim_r0", 2, mem_word(A0));
        cyc(); drv(1, A2, 0, 0, 0);           want("sim_addr_ok", 0, 1); want("sim_data_ok", 1, 1);
                                              want("sim_r1", 2, mem_word(A1));
        cyc(); drv(0, 0, 1, 0, 0);            want("sim_araddr", 4, A2);
        cyc(); drv(1, A3, 0, 0, 0);           want("sim_cnt1", 0, 1);
        cyc(); drv(0, 0, 1, 0, 0);            want("sim_araddr3", 4, A3);
        cyc(); drv(1, A4, 0, 0, 0);           want("sim_cnt2_full", 0, 0);
        cyc(); drv(0, 0, 0, 1, mem_word(A2));
        cyc(); drv(0, 0, 0, 1, mem_word(A3)); want("dr_r2", 2, mem_word(A2)); want("dr_d2", 1, 1);
        cyc(); drv(0, 0, 0, 0, 0);            want("dr_r3", 2, mem_word(A3));
        cyc();                                want("dr_idle", 1, 0); want("dr_depth", 6, 0);

        // Reset mid-flight
        cyc(); drv(1, A0, 0, 0, 0);           want("rm_acc0", 0, 1);
        cyc(); drv(0, 0, 1, 0, 0);
        cyc(); drv(1, A1, 0, 0, 0);           want("rm_acc1", 0, 1);
        cyc(); drv(0, 0, 0, 0, 0);            want("rm_arvalid", 3, 1);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; drv(1, A2, 0, 0, 0);
        want("rm_arvalid_clr", 3, 0); want("rm_data_ok_clr", 1, 0); want("rm_cnt_clr", 0, 1);
        cyc(); drv(0, 0, 1, 0, 0);            want("rm_araddr", 4, A2);
        cyc(); drv(0, 0, 0, 1, mem_word(A2));
        cyc(); drv(0, 0, 0, 0, 0);            want("rm_rdata", 2, mem_word(A2));
        cyc();

        // Ordering: three back-to-back fetches with an eager memory
        mem_en = 1'b1;
        tgt = n_acc + 3;
        fetch_en = 1'b1;
        for (int i = 0; i < 200 && n_acc < tgt; i++) cyc();
        fetch_en = 1'b0;
        wait_drain("ord_drain");

        // Randomized traffic
        req_pct = 60; drop_pct = 15; ar_pct = 60; r_pct = 50;
        fetch_en = 1'b1;
        repeat (3000) cyc();
        fetch_en = 1'b0;
        wait_drain("rnd_drain");

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
